mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port DA_VINCI system memory.
- Requester C is the processor memory interface. Requester D is the debug/loader port, which replaces simulation-only memory preload and dump with a hardware path.
- Serialises accesses with round-robin fairness and drives the memory READ/WRITE/ADDR/DATA pins with a fixed, parameterised access time.
- Sits between DA_VINCI's processor and memory instances.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the processor (C) and debug (D) requesters, the arbiter and
// the single-port system memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  logic              busy;
  logic              owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_data_out,
    output c_rdata, c_ack, d_rdata, d_ack,
    output mem_read, mem_write, mem_addr, mem_data_in,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_data_out,
    input  c_rdata, c_ack, d_rdata, d_ack,
    input  mem_read, mem_write, mem_addr, mem_data_in,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port system memory:
// serialises processor (C) and debug (D) accesses with a fixed strobe time.
module mem_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t            state_r;
  logic              last_r;
  logic              we_r;
  logic [3:0]        cnt_r;

  logic              any_req_s;
  logic              pick_d_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Grant selection: on a tie the requester that did not win last time goes next.
  always_comb begin
    any_req_s = bus.c_req | bus.d_req;
    pick_d_s  = bus.d_req & (~bus.c_req | ~last_r);
    if (pick_d_s) begin
      sel_we_s    = bus.d_we;
      sel_addr_s  = bus.d_addr;
      sel_wdata_s = bus.d_wdata;
    end else begin
      sel_we_s    = bus.c_we;
      sel_addr_s  = bus.c_addr;
      sel_wdata_s = bus.c_wdata;
    end
  end

  // Access sequencer; every output is a register, reset drops the strobes at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r         <= IDLE;
      last_r          <= 1'b1;
      we_r            <= 1'b0;
      cnt_r           <= 4'd0;
      bus.owner       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_addr    <= {ADDR_W{1'b0}};
      bus.mem_data_in <= {DATA_W{1'b0}};
      bus.c_rdata     <= {DATA_W{1'b0}};
      bus.d_rdata     <= {DATA_W{1'b0}};
      bus.c_ack       <= 1'b0;
      bus.d_ack       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.c_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          if (any_req_s) begin
            state_r         <= ACCESS;
            bus.busy        <= 1'b1;
            bus.owner       <= pick_d_s;
            we_r            <= sel_we_s;
            cnt_r           <= CNT_LOAD;
            bus.mem_addr    <= sel_addr_s;
            bus.mem_data_in <= sel_wdata_s;
            bus.mem_read    <= ~sel_we_s;
            bus.mem_write   <= sel_we_s;
          end else begin
            bus.busy      <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            state_r       <= ACK;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            // Read data is taken on the last strobe cycle, only into the owner's port.
            if (bus.owner) begin
              bus.d_ack <= 1'b1;
              if (!we_r) begin
                bus.d_rdata <= bus.mem_data_out;
              end else begin
                bus.d_rdata <= bus.d_rdata;
              end
            end else begin
              bus.c_ack <= 1'b1;
              if (!we_r) begin
                bus.c_rdata <= bus.mem_data_out;
              end else begin
                bus.c_rdata <= bus.c_rdata;
              end
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ACK: begin
          state_r   <= IDLE;
          bus.busy  <= 1'b0;
          bus.c_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          last_r    <= bus.owner;
        end
        default: begin
          state_r       <= IDLE;
          bus.busy      <= 1'b0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.c_ack     <= 1'b0;
          bus.d_ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-timeline model for the MEM_LAT=2 instance plus
// directed literal checks, and a MEM_LAT=1 instance for the short-strobe case.
module tb_mem_port_arbiter;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   pcyc     = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) pcyc <= pcyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1)
  );

  // Environment memories (what the DUTs really talk to) and the model's memory.
  logic [DW-1:0] env0 [logic [AW-1:0]];
  logic [DW-1:0] env1 [logic [AW-1:0]];
  logic [DW-1:0] mmem [logic [AW-1:0]];
  logic [AW-1:0] pool [8];
  logic          own_q [$];
  int            t_q [$];

  // Model state: the last granted transaction and the edge it was granted on.
  bit            m_active;
  int            m_g, m_cyc;
  logic          m_owner, m_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_crd, m_drd;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit to_d;
    if (RST !== 1'b1) begin
      m_active = 1'b0; m_cyc = 0; m_g = 0;
      m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_crd = '0; m_drd = '0;
      return;
    end
    m_cyc++;
    if (m_active && (m_cyc - m_g == LAT)) begin
      if (m_we) mmem[m_addr] = m_wdata;
      else if (m_owner) m_drd = mread(m_addr);
      else m_crd = mread(m_addr);
    end
    if (!m_active || (m_cyc - m_g >= LAT + 2)) begin
      if (bus0.c_req || bus0.d_req) begin
        if (bus0.c_req && bus0.d_req) to_d = (m_last == 1'b0);
        else to_d = bus0.d_req;
        m_active = 1'b1; m_g = m_cyc; m_owner = to_d; m_last = to_d;
        m_we    = to_d ? bus0.d_we    : bus0.c_we;
        m_addr  = to_d ? bus0.d_addr  : bus0.c_addr;
        m_wdata = to_d ? bus0.d_wdata : bus0.c_wdata;
      end
    end
  endtask

  task automatic compare();
    int d; bit strobe, ack;
    d      = m_cyc - m_g;
    strobe = m_active && (d < LAT);
    ack    = m_active && (d == LAT);
    check("mem_read",    bus0.mem_read,    strobe && !m_we);
    check("mem_write",   bus0.mem_write,   strobe && m_we);
    check("mem_addr",    bus0.mem_addr,    m_addr);
    check("mem_data_in", bus0.mem_data_in, m_wdata);
    check("c_ack",       bus0.c_ack,       ack && !m_owner);
    check("d_ack",       bus0.d_ack,       ack && m_owner);
    check("c_rdata",     bus0.c_rdata,     m_crd);
    check("d_rdata",     bus0.d_rdata,     m_drd);
    check("busy",        bus0.busy,        m_active && (d <= LAT));
    check("owner",       bus0.owner,       m_owner);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    if (RST === 1'b1) compare();
  end

  initial forever begin
    @(negedge CLK);
    if (bus0.mem_write === 1'b1) env0[bus0.mem_addr] = bus0.mem_data_in;
    if (bus1.mem_write === 1'b1) env1[bus1.mem_addr] = bus1.mem_data_in;
    bus0.mem_data_out = env0.exists(bus0.mem_addr) ? env0[bus0.mem_addr] : dflt(bus0.mem_addr);
    bus1.mem_data_out = env1.exists(bus1.mem_addr) ? env1[bus1.mem_addr] : dflt(bus1.mem_addr);
  end

  task automatic go(input bit b1, input bit is_d, input logic we, input logic [AW-1:0] a,
                    input logic [DW-1:0] w, output int ns, output int ai, output int ac);
    bit seen; logic stb, ak;
    if (b1 && is_d) begin bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_addr = a; bus1.d_wdata = w; end
    else if (b1)    begin bus1.c_req = 1'b1; bus1.c_we = we; bus1.c_addr = a; bus1.c_wdata = w; end
    else if (is_d)  begin bus0.d_req = 1'b1; bus0.d_we = we; bus0.d_addr = a; bus0.d_wdata = w; end
    else            begin bus0.c_req = 1'b1; bus0.c_we = we; bus0.c_addr = a; bus0.c_wdata = w; end
    ns = 0; ai = 0; ac = 0; seen = 1'b0;
    for (int i = 1; i <= 80 && !seen; i++) begin
      @(negedge CLK);
      if (b1) begin
        stb = (bus1.mem_read | bus1.mem_write) & (bus1.owner == is_d);
        ak  = is_d ? bus1.d_ack : bus1.c_ack;
      end else begin
        stb = (bus0.mem_read | bus0.mem_write) & (bus0.owner == is_d);
        ak  = is_d ? bus0.d_ack : bus0.c_ack;
      end
      if (stb === 1'b1) ns++;
      if (ak === 1'b1) begin seen = 1'b1; ai = i; ac = pcyc; end
    end
    check("ack_seen", seen, 1'b1);
    @(posedge CLK);
    #1;
  endtask

  task automatic drop(input bit b1, input bit is_d);
    if (b1) begin
      if (is_d) bus1.d_req = 1'b0; else bus1.c_req = 1'b0;
    end else begin
      if (is_d) bus0.d_req = 1'b0; else bus0.c_req = 1'b0;
    end
  endtask

  task automatic monitor(input int n);
    int k;
    k = 0;
    for (int i = 0; i < 80 && k < n; i++) begin
      @(negedge CLK);
      if (bus0.c_ack === 1'b1 || bus0.d_ack === 1'b1) begin
        own_q.push_back(bus0.owner);
        t_q.push_back(pcyc);
        k++;
      end
    end
  endtask

  task automatic agent(input bit is_d, input int n);
    int ns, ai, ac; logic we; logic [AW-1:0] a; logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = pool[$urandom_range(0, 7)];
      w  = $urandom;
      go(1'b0, is_d, we, a, w, ns, ai, ac);
      if ($urandom_range(0, 2) != 0) begin
        drop(1'b0, is_d);
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        #1;
      end
    end
    drop(1'b0, is_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int ns, ai, ac, ac_prev;
    pool = '{26'h0000010, 26'h0000011, 26'h0040000, 26'h0048000,
             26'h1234567, 26'h2AAAAAA, 26'h3FFFFFF, 26'h0000000};
    {bus0.c_req, bus0.c_we, bus0.d_req, bus0.d_we} = 4'b0;
    {bus1.c_req, bus1.c_we, bus1.d_req, bus1.d_we} = 4'b0;
    bus0.c_addr = '0; bus0.c_wdata = '0; bus0.d_addr = '0; bus0.d_wdata = '0;
    bus1.c_addr = '0; bus1.c_wdata = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus0.mem_data_out = '0; bus1.mem_data_out = '0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_owner", bus0.owner, 1'b0);
    check("rst_c_rdata", bus0.c_rdata, 32'h0);
    @(posedge CLK);
    #1;

    // Single processor read
    env0[26'h0040000] = 32'h0000_0001; mmem[26'h0040000] = 32'h0000_0001;
    go(1'b0, 1'b0, 1'b0, 26'h0040000, 32'h0, ns, ai, ac);
    drop(1'b0, 1'b0);
    check("t1_strobes", ns, 32'd2);
    check("t1_ack_idx", ai, 32'd4);
    check("t1_c_rdata", bus0.c_rdata, 32'h0000_0001);
    check("t1_d_rdata", bus0.d_rdata, 32'h0);

    // Debug write followed by a processor read of the same word
    go(1'b0, 1'b1, 1'b1, 26'h0048000, 32'hDEAD_BEEF, ns, ai, ac);
    drop(1'b0, 1'b1);
    check("t2_wr_strobes", ns, 32'd2);
    check("t2_mem_data_in", bus0.mem_data_in, 32'hDEAD_BEEF);
    go(1'b0, 1'b0, 1'b0, 26'h0048000, 32'h0, ns, ai, ac);
    drop(1'b0, 1'b0);
    check("t2_c_rdata", bus0.c_rdata, 32'hDEAD_BEEF);
    check("t2_d_rdata", bus0.d_rdata, 32'h0);

    // Both requesters held from reset: strict alternation starting with C
    @(posedge CLK);
    #2 RST = 1'b0;
    bus0.c_req = 1'b1; bus0.c_we = 1'b0; bus0.c_addr = 26'h0000010;
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 26'h0000011;
    @(posedge CLK);
    #2 RST = 1'b1;
    own_q.delete(); t_q.delete();
    fork
      begin
        go(1'b0, 1'b0, 1'b0, 26'h0000010, 32'h0, ns, ai, ac);
        go(1'b0, 1'b0, 1'b0, 26'h0040000, 32'h0, ns, ai, ac);
        drop(1'b0, 1'b0);
      end
      begin
        go(1'b0, 1'b1, 1'b0, 26'h0000011, 32'h0, ns, ai, ac);
        go(1'b0, 1'b1, 1'b0, 26'h0048000, 32'h0, ns, ai, ac);
        drop(1'b0, 1'b1);
      end
      monitor(4);
    join
    check("t3_count", own_q.size(), 32'd4);
    if (own_q.size() == 4) begin
      check("t3_own0", own_q[0], 1'b0);
      check("t3_own1", own_q[1], 1'b1);
      check("t3_own2", own_q[2], 1'b0);
      check("t3_own3", own_q[3], 1'b1);
    end
    for (int i = 1; i < t_q.size(); i++) check("t3_gap", t_q[i] - t_q[i-1], 32'd4);

    // C requests continuously, D arrives during C's access
    own_q.delete(); t_q.delete();
    fork
      begin
        go(1'b0, 1'b0, 1'b0, 26'h1234567, 32'h0, ns, ai, ac);
        go(1'b0, 1'b0, 1'b0, 26'h0000010, 32'h0, ns, ai, ac);
        drop(1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge CLK);
        #1;
        go(1'b0, 1'b1, 1'b1, 26'h2AAAAAA, 32'h0F0F_1234, ns, ai, ac);
        drop(1'b0, 1'b1);
      end
      monitor(3);
    join
    check("t4_count", own_q.size(), 32'd3);
    if (own_q.size() == 3) begin
      check("t4_own0", own_q[0], 1'b0);
      check("t4_own1", own_q[1], 1'b1);
      check("t4_own2", own_q[2], 1'b0);
    end
    for (int i = 1; i < t_q.size(); i++) check("t4_gap", t_q[i] - t_q[i-1], 32'd4);

    // Reset during the first strobe cycle of a write
    bus0.c_req = 1'b1; bus0.c_we = 1'b1; bus0.c_addr = 26'h0000123; bus0.c_wdata = 32'h0BAD_F00D;
    @(posedge CLK);
    #2;
    check("t5_wr_before", bus0.mem_write, 1'b1);
    RST = 1'b0;
    #1;
    check("t5_wr_async", bus0.mem_write, 1'b0);
    check("t5_rd_async", bus0.mem_read, 1'b0);
    bus0.c_req = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t5_no_c_ack", bus0.c_ack, 1'b0);
      check("t5_no_d_ack", bus0.d_ack, 1'b0);
    end
    check("t5_busy", bus0.busy, 1'b0);
    check("t5_owner", bus0.owner, 1'b0);
    check("t5_c_rdata", bus0.c_rdata, 32'h0);
    check("t5_d_rdata", bus0.d_rdata, 32'h0);
    @(posedge CLK);
    #1;

    // Randomised traffic from both requesters against the model
    fork
      agent(1'b0, 25);
      agent(1'b1, 25);
    join
    repeat (6) @(posedge CLK);
    #1;

    // MEM_LAT=1 instance: back-to-back reads at the address extremes
    env1[26'h3FFFFFF] = 32'hA5A5_5A5A;
    env1[26'h0000000] = 32'h1234_5678;
    go(1'b1, 1'b0, 1'b0, 26'h3FFFFFF, 32'h0, ns, ai, ac);
    check("t7_strobes_a", ns, 32'd1);
    check("t7_ack_idx_a", ai, 32'd3);
    check("t7_rdata_a", bus1.c_rdata, 32'hA5A5_5A5A);
    ac_prev = ac;
    go(1'b1, 1'b0, 1'b0, 26'h0000000, 32'h0, ns, ai, ac);
    drop(1'b1, 1'b0);
    check("t7_strobes_b", ns, 32'd1);
    check("t7_ack_gap", ac - ac_prev, 32'd3);
    check("t7_rdata_b", bus1.c_rdata, 32'h1234_5678);
    check("t7_d_rdata", bus1.d_rdata, 32'h0);

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
